operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/of_pkg.sv | 34 +++
 rtl/fwd_select.sv | 41 ++++
 rtl/operand_fetch_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/of_pkg.sv
// Shared types for the operand-fetch stage: decoded uop, forwarding source
// descriptor and the forwarding-hit helper used by every operand selector.
package of_pkg;

  localparam int CTRL_W  = 32;
  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int NUM_OPS = 2;

  // Decoded micro-op as it travels from decode into EX.
  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic [CTRL_W-1:0] ctrl;
  } uop_t;

  // A downstream stage that may write the register file.
  // ld marks a load whose data is not available until MEM completes.
  typedef struct packed {
    logic             we;
    logic             ld;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } fwd_t;

  // A source matches a read only if it really writes a non-zero register.
  function automatic logic fwd_hit(input fwd_t src, input logic [REG_W-1:0] rs);
    return src.we && (src.rd != '0) && (src.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand bypass mux: picks the youngest in-flight producer of rs,
// falling back to register-file data. Also flags a load producer in EX,
// whose data cannot be bypassed yet.
module fwd_select
  import of_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rf_data,
  input  fwd_t             ex_fwd,
  input  fwd_t             mem_fwd,
  input  fwd_t             wb_fwd,
  output logic [XLEN-1:0]  operand,
  output logic             load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = fwd_hit(ex_fwd, rs);
  assign mem_hit = fwd_hit(mem_fwd, rs);
  assign wb_hit  = fwd_hit(wb_fwd, rs);

  // A load in EX matches but has no data yet: caller must stall.
  assign load_hit = ex_hit && ex_fwd.ld;

  // Youngest producer wins; x0 always reads zero. WB is bypassed because
  // its register-file write only lands on the next edge.
  always_comb begin
    operand = rf_data;
    if (rs == '0)
      operand = '0;
    else if (ex_hit && !ex_fwd.ld)
      operand = ex_fwd.data;
    else if (mem_hit)
      operand = mem_fwd.data;
    else if (wb_hit)
      operand = wb_fwd.data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch pipeline stage: reads the register file, resolves bypasses,
// stalls on load-use hazards and registers the uop plus operands for EX
// behind a valid/ready handshake.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  uop_t                   in_uop,
  output logic [REG_W-1:0]       rf_raddr1,
  output logic [REG_W-1:0]       rf_raddr2,
  input  logic [XLEN-1:0]        rf_data1,
  input  logic [XLEN-1:0]        rf_data2,
  input  fwd_t                   ex_fwd,
  input  fwd_t                   mem_fwd,
  input  fwd_t                   wb_fwd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output uop_t                   out_uop,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [NUM_OPS-1:0][REG_W-1:0] rs_sel;
  logic [NUM_OPS-1:0][XLEN-1:0]  rf_sel;
  logic [NUM_OPS-1:0][XLEN-1:0]  op_res;
  logic [NUM_OPS-1:0]            load_hit;

  logic hazard;
  logic out_free;
  logic accept;

  assign rs_sel[0] = in_uop.rs1;
  assign rs_sel[1] = in_uop.rs2;
  assign rf_sel[0] = rf_data1;
  assign rf_sel[1] = rf_data2;

  assign rf_raddr1 = in_uop.rs1;
  assign rf_raddr2 = in_uop.rs2;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_select u_sel (
      .rs       (rs_sel[i]),
      .rf_data  (rf_sel[i]),
      .ex_fwd   (ex_fwd),
      .mem_fwd  (mem_fwd),
      .wb_fwd   (wb_fwd),
      .operand  (op_res[i]),
      .load_hit (load_hit[i])
    );
  end

  assign hazard   = in_valid && (|load_hit);
  assign out_free = !out_valid || out_ready;
  assign in_ready = !flush && !hazard && out_free;
  assign accept   = in_valid && in_ready;

  // Output valid: flush kills, accept fills, a free slot with no accept
  // becomes a bubble, otherwise the held uop stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid <= 1'b0;
    else if (flush)
      out_valid <= 1'b0;
    else if (accept)
      out_valid <= 1'b1;
    else if (out_free)
      out_valid <= 1'b0;
  end

  // Payload only loads on accept, so a stalled output never re-resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_uop <= '0;
      out_op1 <= '0;
      out_op2 <= '0;
    end else if (accept) begin
      out_uop <= in_uop;
      out_op1 <= op_res[0];
      out_op2 <= op_res[1];
    end
  end

  // Saturating count of load-use stall cycles; flushed cycles do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (hazard && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
